mem_stall_ctrl: RTL and testbench

Parametrised pipeline stall controller for N memory channels (instruction fetch, data/external bus, further masters). Each channel runs its own wait tracker, started by an access start pulse and finished by a done pulse. While a channel is waiting, the pipeline-stage and PC enables selected by that channel's stall mask are suppressed. The block sits between the hazard/enable logic and the pipeline registers. It generalises the fixed two-channel, 4-stage enable combiner to N_CH channels with per-channel masks, priority override and an optional timeout.

---
 rtl/mem_stall_pkg.sv | 29 ++
 rtl/mem_wait_channel.sv | 77 +++++++
 rtl/mem_stall_ctrl.sv | 62 ++++++
 tb/tb_mem_stall_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stall_pkg.sv
// Shared types and helpers for the memory stall controller: channel state
// encoding, stall-field width and per-channel mask field extraction.
package mem_stall_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAITING = 2'd1,
      ST_DONE    = 2'd2
   } ch_state_t;

   localparam int unsigned MASK_MAX_W = 256;
   localparam int unsigned FIELD_MAX_W = 32;

   function automatic int unsigned field_width(input int unsigned n_stages);
      return n_stages + 1;
   endfunction

   // Returns channel ch's field (PC in bit 0, stages above), zero-extended.
   function automatic logic [FIELD_MAX_W-1:0] mask_field(
      input logic [MASK_MAX_W-1:0] mask,
      input int unsigned           ch,
      input int unsigned           fw
   );
      logic [MASK_MAX_W-1:0] sel;
      sel = (mask >> (ch * fw)) & ((MASK_MAX_W'(1) << fw) - MASK_MAX_W'(1));
      return FIELD_MAX_W'(sel);
   endfunction

endpackage

// File: rtl/mem_wait_channel.sv
// Per-channel wait tracker: IDLE/WAITING/DONE FSM with stall, busy and
// done-state outputs. MEM_STALL_TIMEOUT_EN adds a forced-release counter.
//
// state      | meaning
// ST_IDLE    | no access outstanding
// ST_WAITING | access started, done not yet seen; stalls its masked enables
// ST_DONE    | access completed last edge; masks lower-priority stalls
module mem_wait_channel
   import mem_stall_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk_sys,
   input  logic rst_b,
   input  logic start,
   input  logic done,
   output logic stall,
   output logic busy,
   output logic in_done,
   output logic timeout
);

   ch_state_t state_q, state_d;
   logic      tmo_hit;

   if (TIMEOUT < 1) begin : g_cfg_check
      $error("mem_wait_channel: TIMEOUT must be at least 1");
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start && !done) begin
               state_d = ST_WAITING;
               stall   = 1'b1;
            end else if (start && done) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAITING: begin
            if (done || tmo_hit) state_d = ST_DONE;
            else                 stall   = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

`ifdef MEM_STALL_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q;

   // Held at zero outside WAITING so it reads 0 on the first waiting cycle.
   always_ff @(posedge clk_sys) begin
      if (!rst_b)                      cnt_q <= '0;
      else if (state_q != ST_WAITING)  cnt_q <= '0;
      else                             cnt_q <= cnt_q + 1'b1;
   end

   assign tmo_hit = (state_q == ST_WAITING) && !done && (cnt_q == CNT_W'(TIMEOUT));
`else
   assign tmo_hit = 1'b0;
`endif

   assign timeout = tmo_hit;
   assign busy    = (state_q == ST_WAITING);
   assign in_done = (state_q == ST_DONE);

endmodule

// File: rtl/mem_stall_ctrl.sv
// N-channel pipeline stall controller: priority override, stall-mask OR and
// enable gating over per-channel wait trackers (timeout via MEM_STALL_TIMEOUT_EN).
module mem_stall_ctrl
   import mem_stall_pkg::*;
#(
   parameter int unsigned                   N_CH       = 2,
   parameter int unsigned                   N_STAGES   = 4,
   parameter logic [N_CH*(N_STAGES+1)-1:0] STALL_MASK = '1,
   parameter int unsigned                   TIMEOUT    = 255
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic [N_CH-1:0]     start_i,
   input  logic [N_CH-1:0]     done_i,
   input  logic                en_pc_i,
   input  logic [N_STAGES-1:0] en_stage_i,
   output logic                en_pc_o,
   output logic [N_STAGES-1:0] en_stage_o,
   output logic [N_CH-1:0]     busy_o,
   output logic [N_CH-1:0]     timeout_o
);

   localparam int unsigned FW = field_width(N_STAGES);

   logic [N_CH-1:0] stall;
   logic [N_CH-1:0] in_done;
   logic [FW-1:0]   ch_mask [N_CH];
   logic [FW-1:0]   stall_vec;
   logic            higher_done;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      assign ch_mask[k] = FW'(mask_field(MASK_MAX_W'(STALL_MASK), k, FW));

      mem_wait_channel #(
         .TIMEOUT (TIMEOUT)
      ) u_ch (
         .clk_sys (CLK),
         .rst_b   (RST_N),
         .start   (start_i[k]),
         .done    (done_i[k]),
         .stall   (stall[k]),
         .busy    (busy_o[k]),
         .in_done (in_done[k]),
         .timeout (timeout_o[k])
      );
   end

   // A channel in DONE hides the stall of every lower-priority channel.
   always_comb begin
      stall_vec   = '0;
      higher_done = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (stall[k] && !higher_done) stall_vec = stall_vec | ch_mask[k];
         higher_done = higher_done | in_done[k];
      end
      if (!RST_N) stall_vec = '0;
   end

   assign en_pc_o    = en_pc_i & ~stall_vec[0];
   assign en_stage_o = en_stage_i & ~stall_vec[FW-1:1];

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Scoreboard bench for mem_stall_ctrl: two instances (full masks and a
// partial mask set) share stimulus and are checked against a channel model.
module tb_mem_stall_ctrl;

   localparam int N_CH = 2;
   localparam int NS   = 4;
   localparam int TMO  = 8;
`ifdef MEM_STALL_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   typedef struct {
      logic [4:0] en_a;
      logic [4:0] en_b;
      logic [1:0] busy;
      logic [1:0] tmo;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      start, done;
   logic            en_pc;
   logic [NS-1:0]   en_stage;
   logic            pc_a, pc_b;
   logic [NS-1:0]   stg_a, stg_b;
   logic [1:0]      busy_a, busy_b, tmo_a, tmo_b;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   bit         pend [2];
   bit         rel  [2];
   int         wcnt [2];
   logic [4:0] mask_a [2];
   logic [4:0] mask_b [2];

   always #5 clk = ~clk;

   mem_stall_ctrl #(.N_CH(N_CH), .N_STAGES(NS), .TIMEOUT(TMO)) dut_a (
      .CLK(clk), .RST_N(rst_n), .start_i(start), .done_i(done),
      .en_pc_i(en_pc), .en_stage_i(en_stage),
      .en_pc_o(pc_a), .en_stage_o(stg_a), .busy_o(busy_a), .timeout_o(tmo_a)
   );

   mem_stall_ctrl #(.N_CH(N_CH), .N_STAGES(NS), .STALL_MASK(10'b00011_10110),
                    .TIMEOUT(TMO)) dut_b (
      .CLK(clk), .RST_N(rst_n), .start_i(start), .done_i(done),
      .en_pc_i(en_pc), .en_stage_i(en_stage),
      .en_pc_o(pc_b), .en_stage_o(stg_b), .busy_o(busy_b), .timeout_o(tmo_b)
   );

   function automatic void chk(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("en_full_mask", {3'b0, stg_a, pc_a}, {3'b0, e.en_a});
         chk("en_part_mask", {3'b0, stg_b, pc_b}, {3'b0, e.en_b});
         chk("busy",         {6'b0, busy_a},      {6'b0, e.busy});
         chk("busy_b",       {6'b0, busy_b},      {6'b0, e.busy});
         chk("timeout",      {6'b0, tmo_a},       {6'b0, e.tmo});
         chk("timeout_b",    {6'b0, tmo_b},       {6'b0, e.tmo});
      end
   end

   // One clock of stimulus: drive, predict this cycle's outputs, advance model.
   task automatic cyc(input bit r, input logic [1:0] st, input logic [1:0] dn,
                      input bit epc, input logic [NS-1:0] est);
      exp_t       e;
      logic [4:0] sa, sb, en;
      bit         higher, req;
      bit         tmo [2];
      @(posedge clk);
      #1;
      rst_n = r; start = st; done = dn; en_pc = epc; en_stage = est;
      sa = '0; sb = '0; higher = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tmo[k] = TMO_EN && pend[k] && !dn[k] && (wcnt[k] == TMO);
         req    = pend[k] ? (!dn[k] && !tmo[k]) : (st[k] && !dn[k]);
         if (req && !higher) begin
            sa = sa | mask_a[k];
            sb = sb | mask_b[k];
         end
         higher = higher | rel[k];
         e.busy[k] = pend[k];
         e.tmo[k]  = tmo[k];
      end
      if (!r) begin
         sa = '0; sb = '0;
      end
      en = {est, epc};
      e.en_a = en & ~sa;
      e.en_b = en & ~sb;
      q.push_back(e);
      for (int k = 0; k < 2; k++) begin
         if (!r) begin
            pend[k] = 0; rel[k] = 0; wcnt[k] = 0;
         end else if (pend[k]) begin
            if (dn[k] || tmo[k]) begin
               pend[k] = 0; rel[k] = 1;
            end else begin
               rel[k] = 0; wcnt[k]++;
            end
         end else if (st[k] && !dn[k]) begin
            pend[k] = 1; rel[k] = 0; wcnt[k] = 0;
         end else begin
            rel[k] = st[k] && dn[k];
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 2'b00, 2'b00, 1, 4'hF);
   endtask

   initial begin
      int budget;
      mask_a[0] = 5'b11111; mask_a[1] = 5'b11111;
      mask_b[0] = 5'b10110; mask_b[1] = 5'b00011;
      for (int k = 0; k < 2; k++) begin
         pend[k] = 0; rel[k] = 0; wcnt[k] = 0;
      end
      rst_n = 0; start = 0; done = 0; en_pc = 1; en_stage = 4'hF;
      @(posedge clk);
      cyc(0, 2'b00, 2'b00, 1, 4'hF);
      idle(2);

      // channel 1 access: start at cycle 0, done at cycle 5
      cyc(1, 2'b10, 2'b00, 1, 4'hF);
      idle(4);
      cyc(1, 2'b00, 2'b10, 1, 4'hF);
      idle(3);

      // zero-wait access on channel 0
      cyc(1, 2'b01, 2'b01, 1, 4'hF);
      idle(2);

      // override: ch0 in DONE while ch1 starts
      cyc(1, 2'b01, 2'b01, 1, 4'hF);
      cyc(1, 2'b10, 2'b00, 1, 4'hF);
      idle(2);
      cyc(1, 2'b00, 2'b10, 1, 4'hF);
      idle(2);

      // reset abandons a waiting access; a late done is ignored
      cyc(1, 2'b10, 2'b00, 1, 4'hF);
      idle(2);
      cyc(0, 2'b00, 2'b00, 1, 4'hA);
      idle(2);
      cyc(1, 2'b00, 2'b10, 1, 4'hF);
      idle(2);

      // long wait on channel 0 (forced release when the timeout is built in)
      cyc(1, 2'b01, 2'b00, 1, 4'hF);
      idle(13);
      cyc(1, 2'b00, 2'b01, 1, 4'hF);
      idle(2);

      for (int i = 0; i < 800; i++) begin
         logic [1:0] st, dn;
         st[0] = ($urandom_range(0, 3) == 0);
         st[1] = ($urandom_range(0, 3) == 0);
         dn[0] = ($urandom_range(0, 4) == 0);
         dn[1] = ($urandom_range(0, 4) == 0);
         cyc(($urandom_range(0, 79) != 0), st, dn, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      end
      idle(2);

      budget = 0;
      while (q.size() > 0 && budget < 20) begin
         @(posedge clk);
         budget++;
      end
      @(posedge clk);
      if (q.size() > 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
